uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `serial_transmitter` byte FIFO between several requesters (debug console, status reporter, log streamer, and so on). Each requester presents a byte stream framed by a `last` flag. Once a requester is granted, its whole packet enters the transmitter FIFO contiguously, so packets from different sources never interleave on TX. A burst limit stops any single source from monopolising the link.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter sharing one serial_transmitter byte FIFO
//   between NUM_REQ requesters. A granted requester keeps the FIFO until the
//   byte flagged `last` is accepted, or until MAX_BURST bytes have gone in.
//
// Ports
//   clk        system clock
//   srst       synchronous active-high reset
//   req_valid  per-requester byte valid
//   req_data   packed request bytes, requester i on [8*i+:8]
//   req_last   per-requester end-of-packet flag, qualified by acceptance
//   req_ready  per-requester accept strobe (combinational)
//   tx_wr_en   write strobe into the transmitter FIFO (combinational)
//   tx_din     byte written into the transmitter FIFO (combinational)
//   tx_full    transmitter FIFO full
//   grant      one-hot current owner, zero when idle (registered)
//   burst_cut  one-cycle pulse when a grant ends on the burst limit (registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; round-robin pick among req_valid, nothing accepted
// OWN   | owner = last_idx; its bytes pass to the FIFO while not full

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_wr_en,
    output logic [7:0]             tx_din,
    input  logic                   tx_full,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   burst_cut
);

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [IDX_W-1:0]     last_idx, last_idx_n;
    logic [IDX_W-1:0]     win_idx, cand;
    logic [7:0]           cnt, cnt_n;
    logic                 burst_cut_n;
    logic                 own_valid, own_last, accept;
    logic [7:0]           own_data;

    // Owner lanes are selected with the one-hot grant, so no index decode
    // sits in the write path.
    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) own_data = req_data[8*i +: 8];
        end
    end

    assign own_valid = |(req_valid & grant);
    assign own_last  = |(req_last & grant);
    assign accept    = (state == OWN) && own_valid && !tx_full && !srst;

    // Scan last_idx+NUM_REQ down to last_idx+1 so the closest valid index
    // after the previous winner is the one left standing.
    always_comb begin
        win_idx = last_idx;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (req_valid[cand]) win_idx = cand;
        end
    end

    always_comb begin
        req_ready = '0;
        tx_wr_en  = 1'b0;
        tx_din    = '0;
        if (!srst && state == OWN) begin
            req_ready = grant & {NUM_REQ{~tx_full}};
            tx_wr_en  = accept;
            tx_din    = own_data;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        last_idx_n  = last_idx;
        cnt_n       = cnt;
        burst_cut_n = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n    = OWN;
                    grant_n    = NUM_REQ'(1) << win_idx;
                    last_idx_n = win_idx;
                    cnt_n      = '0;
                end
            end
            OWN: begin
                if (accept) begin
                    cnt_n = cnt + 8'd1;
                    // last wins over the limit: a packet ending exactly on
                    // the limit is a normal release.
                    if (own_last) begin
                        state_n = IDLE;
                        grant_n = '0;
                    end else if (cnt + 8'd1 == BURST_LIM) begin
                        state_n     = IDLE;
                        grant_n     = '0;
                        burst_cut_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            grant     <= '0;
            last_idx  <= IDX_W'(NUM_REQ - 1);
            cnt       <= '0;
            burst_cut <= 1'b0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            last_idx  <= last_idx_n;
            cnt       <= cnt_n;
            burst_cut <= burst_cut_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: packet sources per requester, a packet-level
// reference model of ownership, and a per-cycle compare of all outputs.

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int QD = 4096;

    logic           clk = 1'b0;
    logic           srst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_wr_en;
    logic [7:0]     tx_din;
    logic           tx_full;
    logic [N-1:0]   grant;
    logic           burst_cut;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .srst      (srst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_wr_en  (tx_wr_en),
        .tx_din    (tx_din),
        .tx_full   (tx_full),
        .grant     (grant),
        .burst_cut (burst_cut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // packet sources: {last, data} per entry
    logic [8:0] src_mem [N][QD];
    int         head [N];
    int         tail [N];
    bit         hold [N];

    // reference model: who owns the link, and how many bytes this grant took
    int   m_owner;
    int   m_ptr;
    int   m_taken;
    bit   m_cut;

    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    int         seen_cyc[$];
    int         grant_seq[$];
    int         cut_seen = 0;
    int         rdy3_seen = 0;
    int         cyc = 0;
    logic [N-1:0] prev_grant = '0;
    bit         chk_on = 1'b0;

    logic [N-1:0] e_grant, e_rdy;
    logic         e_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input int base, input bit with_last);
        for (int j = 0; j < len; j++) begin
            if (tail[r] < QD) begin
                src_mem[r][tail[r]] = {with_last && (j == len - 1), 8'(base + j)};
                tail[r]++;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i] && !hold[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_mem[i][head[i]][7:0];
                req_last[i]        = src_mem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Edge-level behaviour: idle link picks the next valid requester after
    // the previous winner; an owned link moves one byte when the owner offers
    // one and the FIFO has room; the grant ends on `last` or after MB bytes.
    task automatic model_edge();
        int c;
        if (srst) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_taken = 0;
            m_cut   = 1'b0;
            return;
        end
        m_cut = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (req_valid[c] && m_owner < 0) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_taken = 0;
                end
            end
        end else if (req_valid[m_owner] && !tx_full) begin
            exp_q.push_back(req_data[8*m_owner +: 8]);
            head[m_owner]++;
            m_taken++;
            if (req_last[m_owner]) begin
                m_owner = -1;
            end else if (m_taken == MB) begin
                m_owner = -1;
                m_cut   = 1'b1;
            end
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            e_rdy   = (!srst && m_owner >= 0 && !tx_full) ? e_grant : '0;
            e_wr    = !srst && (m_owner >= 0) && req_valid[m_owner] && !tx_full;
            chk("grant", 32'(grant), 32'(e_grant));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("tx_wr_en", 32'(tx_wr_en), 32'(e_wr));
            chk("burst_cut", 32'(burst_cut), 32'(m_cut));
            if (e_wr) chk("tx_din", 32'(tx_din), 32'(req_data[8*m_owner +: 8]));
            if (srst) chk("tx_din_in_reset", 32'(tx_din), 32'h0);
        end
        if (tx_wr_en) begin
            seen_q.push_back(tx_din);
            seen_cyc.push_back(cyc);
        end
        if (grant != '0 && prev_grant == '0) grant_seq.push_back($clog2(grant));
        prev_grant = grant;
        if (burst_cut) cut_seen++;
        if (req_ready[3]) rdy3_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, gs0, c0, r3, budget, pending, mism, nmin;
        int rr_exp [6];
        rr_exp = '{0, 1, 3, 0, 1, 3};

        srst    = 1'b1;
        tx_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
        end
        m_owner = -1;
        m_ptr   = N - 1;
        m_taken = 0;
        m_cut   = 1'b0;
        drive();
        run(2);
        srst   = 1'b0;
        chk_on = 1'b1;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_burst_cut", 32'(burst_cut), 32'h0);

        // round robin from reset: 0,1,3,0,1,3 with one idle cycle per byte
        gs0 = grant_seq.size();
        sb  = seen_q.size();
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, 1, 8'hA0 + p, 1'b1);
            push_pkt(1, 1, 8'hB0 + p, 1'b1);
            push_pkt(3, 1, 8'hD0 + p, 1'b1);
        end
        run(16);
        chk("rr_grant_count", 32'(grant_seq.size() - gs0), 32'd6);
        if (grant_seq.size() - gs0 >= 6)
            for (int j = 0; j < 6; j++) chk("rr_order", 32'(grant_seq[gs0 + j]), 32'(rr_exp[j]));
        chk("rr_byte_count", 32'(seen_q.size() - sb), 32'd6);
        if (seen_q.size() - sb >= 6)
            for (int j = 1; j < 6; j++) chk("rr_spacing", 32'(seen_cyc[sb + j] - seen_cyc[sb + j - 1]), 32'd2);

        // single packet on req 2
        sb = seen_q.size();
        c0 = cut_seen;
        push_pkt(2, 3, 8'h41, 1'b1);
        step();
        chk("single_grant", 32'(grant), 32'h4);
        run(5);
        chk("single_count", 32'(seen_q.size() - sb), 32'd3);
        if (seen_q.size() - sb >= 3) begin
            for (int j = 0; j < 3; j++) chk("single_byte", 32'(seen_q[sb + j]), 32'h41 + j);
            chk("single_contiguous", 32'(seen_cyc[sb + 2] - seen_cyc[sb]), 32'd2);
        end
        chk("single_release", 32'(grant), 32'h0);
        chk("single_no_cut", 32'(cut_seen - c0), 32'd0);

        // backpressure for 5 cycles in front of byte 3 of 5
        sb = seen_q.size();
        push_pkt(1, 5, 8'h60, 1'b1);
        run(3);
        tx_full = 1'b1;
        repeat (5) begin
            #3;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_wr_en", 32'(tx_wr_en), 32'h0);
            step();
        end
        tx_full = 1'b0;
        #3;
        chk("bp_resume_wr", 32'(tx_wr_en), 32'h1);
        chk("bp_resume_din", 32'(tx_din), 32'h62);
        run(5);
        chk("bp_count", 32'(seen_q.size() - sb), 32'd5);
        chk("bp_source_drained", 32'(tail[1] - head[1]), 32'd0);

        // burst limit: req 1 cut after 4, req 0 served, back to req 1
        gs0 = grant_seq.size();
        c0  = cut_seen;
        push_pkt(1, 10, 8'h10, 1'b1);
        step();
        chk("burst_first_grant", 32'(grant), 32'h2);
        push_pkt(0, 2, 8'h20, 1'b1);
        run(25);
        chk("burst_grant_count", 32'(grant_seq.size() - gs0), 32'd4);
        if (grant_seq.size() - gs0 >= 4) begin
            chk("burst_order0", 32'(grant_seq[gs0]), 32'd1);
            chk("burst_order1", 32'(grant_seq[gs0 + 1]), 32'd0);
            chk("burst_order2", 32'(grant_seq[gs0 + 2]), 32'd1);
        end
        chk("burst_cut_count", 32'(cut_seen - c0), 32'd2);

        // last on the 4th byte is a normal end
        c0 = cut_seen;
        push_pkt(1, 4, 8'h30, 1'b1);
        run(8);
        chk("burst_last_no_cut", 32'(cut_seen - c0), 32'd0);
        chk("burst_last_release", 32'(grant), 32'h0);

        // stalled owner keeps the grant; req 3 waits
        push_pkt(2, 5, 8'h50, 1'b1);
        run(3);
        hold[2] = 1'b1;
        push_pkt(3, 2, 8'h70, 1'b1);
        r3 = rdy3_seen;
        run(20);
        chk("stall_grant", 32'(grant), 32'h4);
        chk("stall_ready3", 32'(rdy3_seen - r3), 32'd0);
        hold[2] = 1'b0;
        run(12);
        chk("stall_done", 32'(grant), 32'h0);
        chk("stall_drained", 32'((tail[2] - head[2]) + (tail[3] - head[3])), 32'd0);

        // reset during byte 2 of 5
        push_pkt(2, 5, 8'h80, 1'b1);
        run(2);
        srst = 1'b1;
        #3;
        chk("rst_wr_en", 32'(tx_wr_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        step();
        srst = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_idle_no_wr", 32'(tx_wr_en), 32'h0);
        head[2] = tail[2];
        push_pkt(0, 1, 8'h90, 1'b1);
        push_pkt(2, 1, 8'h91, 1'b1);
        step();
        chk("rst_rr_restart", 32'(grant), 32'h1);
        run(6);

        // randomized traffic
        for (int t = 0; t < 1500; t++) begin
            tx_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (head[i] == tail[i] && $urandom_range(0, 2) == 0)
                    push_pkt(i, $urandom_range(1, 7), $urandom_range(0, 255), 1'b1);
                hold[i] = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        tx_full = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        budget  = 400;
        pending = 1;
        while (pending != 0 && budget > 0) begin
            pending = 0;
            for (int i = 0; i < N; i++) pending += tail[i] - head[i];
            if (pending != 0) step();
            budget--;
        end
        run(3);
        chk("drain_pending", 32'(pending), 32'd0);

        chk("sb_count", 32'(seen_q.size()), 32'(exp_q.size()));
        mism = 0;
        nmin = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
        for (int j = 0; j < nmin; j++) if (seen_q[j] !== exp_q[j]) mism++;
        chk("sb_data", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
